// File: rtl/rng_pkg.sv
// Shared types and defaults for the octal random generator sequencer.
package rng_pkg;

   localparam int NUM_DIGITS_D  = 5;
   localparam int DIGIT_W_D     = 3;
   localparam int SETTLE_CYC_D  = 2;
   localparam int TIMEOUT_CYC_D = 32;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_KICK    = 3'd1,
      ST_WAIT    = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_CAPTURE = 3'd4,
      ST_DONE    = 3'd5,
      ST_ERROR   = 3'd6
   } state_t;

   // Width of a counter that must hold 0..max_val; never narrower than 1 bit.
   function automatic int cnt_width(input int max_val);
      int w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/rng_digit_bank.sv
// Captured digit register bank with load enable, flat output and indexed read port.
module rng_digit_bank
   import rng_pkg::*;
#(
   parameter int NUM_DIGITS = NUM_DIGITS_D,
   parameter int DIGIT_W    = DIGIT_W_D,
   parameter int IDX_W      = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          load,
   input  logic [NUM_DIGITS*DIGIT_W-1:0] din,
   output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
   input  logic [IDX_W-1:0]              rd_idx,
   output logic [DIGIT_W-1:0]            rd_data
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         digits <= '0;
      else if (load)
         digits <= din;
   end

   // Out-of-range indices read as zero.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (rd_idx == IDX_W'(i))
            rd_data = digits[i*DIGIT_W +: DIGIT_W];
      end
   end

endmodule

// File: rtl/random_gen_ctrl.sv
// Sequencer: kicks the octal random generator, waits for done with timeout,
// settles, then snapshots the digits into the local bank.
//
// state   | meaning
// IDLE    | no result yet, waiting for req rising edge
// KICK    | one cycle, gen_s0 asserted
// WAIT    | waiting for done at address NUM_DIGITS, timeout counter running
// SETTLE  | letting the LFSR outputs stabilise
// CAPTURE | loading gen_data into the bank
// DONE    | digits valid, waiting for next request
// ERROR   | generator timed out, waiting for next request
module random_gen_ctrl
   import rng_pkg::*;
#(
   parameter int NUM_DIGITS  = NUM_DIGITS_D,
   parameter int DIGIT_W     = DIGIT_W_D,
   parameter int SETTLE_CYC  = SETTLE_CYC_D,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_D
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req,
   output logic                          gen_s0,
   input  logic                          gen_done,
   input  logic [7:0]                    gen_addr,
   input  logic [NUM_DIGITS*DIGIT_W-1:0] gen_data,
   output logic                          busy,
   output logic                          valid,
   output logic                          ack,
   output logic                          error,
   output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
   input  logic [2:0]                    rd_idx,
   output logic [DIGIT_W-1:0]            rd_data
);

   localparam int CNT_W = cnt_width(TIMEOUT_CYC);
   localparam int SET_W = cnt_width(SETTLE_CYC);

   state_t           state;
   logic             req_q;
   logic             req_rise;
   logic             done_ok;
   logic [CNT_W-1:0] cnt;
   logic [SET_W-1:0] scnt;

   assign req_rise = req & ~req_q;
   // The first WAIT cycle (cnt == 0) never accepts a done left over from the last run.
   assign done_ok  = gen_done && (gen_addr == 8'(NUM_DIGITS)) && (cnt != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         req_q  <= 1'b0;
         gen_s0 <= 1'b0;
         busy   <= 1'b0;
         valid  <= 1'b0;
         ack    <= 1'b0;
         error  <= 1'b0;
         cnt    <= '0;
         scnt   <= '0;
      end else begin
         req_q <= req;
         ack   <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (req_rise) begin
                  state  <= ST_KICK;
                  gen_s0 <= 1'b1;
                  busy   <= 1'b1;
                  valid  <= 1'b0;
                  error  <= 1'b0;
               end
            end
            ST_KICK: begin
               state  <= ST_WAIT;
               gen_s0 <= 1'b0;
               cnt    <= '0;
            end
            ST_WAIT: begin
               cnt <= cnt + 1'b1;
               if (done_ok) begin
                  if (SETTLE_CYC == 0) begin
                     state <= ST_CAPTURE;
                  end else begin
                     state <= ST_SETTLE;
                     scnt  <= SET_W'(SETTLE_CYC - 1);
                  end
               end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  state <= ST_ERROR;
                  error <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            ST_SETTLE: begin
               if (scnt == '0)
                  state <= ST_CAPTURE;
               else
                  scnt <= scnt - 1'b1;
            end
            ST_CAPTURE: begin
               state <= ST_DONE;
               valid <= 1'b1;
               ack   <= 1'b1;
               busy  <= 1'b0;
            end
            default: begin
               state  <= ST_IDLE;
               gen_s0 <= 1'b0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

   rng_digit_bank #(
      .NUM_DIGITS (NUM_DIGITS),
      .DIGIT_W    (DIGIT_W),
      .IDX_W      (3)
   ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .load    (state == ST_CAPTURE),
      .din     (gen_data),
      .digits  (digits),
      .rd_idx  (rd_idx),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_random_gen_ctrl.sv
// Scoreboard bench for random_gen_ctrl with a behavioural generator model.
module tb_random_gen_ctrl;
   import rng_pkg::*;

   localparam int DW = NUM_DIGITS_D * DIGIT_W_D;

   logic          clk = 1'b0;
   logic          rst;
   logic          req;
   logic          gen_s0;
   logic          gen_done;
   logic [7:0]    gen_addr;
   logic [DW-1:0] gen_data;
   logic          busy, valid, ack, error;
   logic [DW-1:0] digits;
   logic [2:0]    rd_idx;
   logic [DIGIT_W_D-1:0] rd_data;

   always #5 clk = ~clk;

   random_gen_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .gen_s0   (gen_s0),
      .gen_done (gen_done),
      .gen_addr (gen_addr),
      .gen_data (gen_data),
      .busy     (busy),
      .valid    (valid),
      .ack      (ack),
      .error    (error),
      .digits   (digits),
      .rd_idx   (rd_idx),
      .rd_data  (rd_data)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int kicks  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit            is_err;
      logic [DW-1:0] dig;
      int            at;
   } exp_t;
   exp_t sb[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Generator model: on s0 it clears done (unless stale), raises done/addr/data
   // dly negedges later. In stale mode the old done survives until k == 2.
   int            mode_dly   = 5;
   bit            mode_never = 1'b0;
   bit            mode_stale = 1'b0;
   logic [DW-1:0] model_data = '0;

   initial begin
      int k;
      k = -1;
      forever begin
         @(negedge clk);
         if (rst) begin
            k = -1;
         end else if (gen_s0) begin
            k = 0;
            if (!mode_stale) begin
               gen_done = 1'b0;
               gen_addr = 8'd0;
            end
         end else if (k >= 0) begin
            k++;
            if (mode_stale && k == 2) begin
               gen_done = 1'b0;
               gen_addr = 8'd0;
            end
            if (!mode_never && k == mode_dly) begin
               gen_done = 1'b1;
               gen_addr = 8'(NUM_DIGITS_D);
               gen_data = model_data;
               k = -1;
            end
         end
      end
   end

   // Monitor: pops an expectation on every ack or error rising edge.
   initial begin
      logic err_q, s0_q;
      exp_t e;
      err_q = 1'b0;
      s0_q  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            err_q = 1'b0;
            s0_q  = 1'b0;
         end else begin
            if (gen_s0) begin
               kicks++;
               chk("s0_width", s0_q, 0);
            end
            if (ack || (error && !err_q)) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_event: ack=%0b error=%0b at cycle %0d, none expected", ack, error, cyc);
               end else begin
                  e = sb.pop_front();
                  chk("event_kind", {63'd0, ~ack}, {63'd0, e.is_err});
                  chk("event_cycle", cyc, e.at);
                  chk("event_busy", busy, 0);
                  if (!e.is_err) begin
                     chk("ack_digits", digits, e.dig);
                     chk("ack_valid", valid, 1);
                     chk("ack_error", error, 0);
                  end else begin
                     chk("err_valid", valid, 0);
                  end
               end
            end
            err_q = error;
            s0_q  = gen_s0;
         end
      end
   end

   int n_req;

   task automatic issue(input logic [DW-1:0] data, input int dly, input bit never,
                        input bit stale, input bit hold);
      exp_t e;
      @(negedge clk);
      model_data = data;
      mode_dly   = dly;
      mode_never = never;
      mode_stale = stale;
      req        = 1'b1;
      n_req      = cyc + 1;
      e.is_err   = never;
      e.dig      = data;
      e.at       = never ? n_req + TIMEOUT_CYC_D + 1 : n_req + dly + 2 + SETTLE_CYC_D;
      sb.push_back(e);
      @(negedge clk);
      if (!hold) req = 1'b0;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL wait_bound: %0d events pending, expected 0", sb.size());
         sb.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int k0;
      rst = 1'b1; req = 1'b0; gen_done = 1'b0; gen_addr = 8'd0; gen_data = '0; rd_idx = 3'd0;

      // 1. reset then idle
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s0", gen_s0, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", valid, 0);
      chk("rst_ack", ack, 0);
      chk("rst_error", error, 0);
      chk("rst_digits", digits, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("idle_kicks", kicks, 0);
      chk("idle_state", dut.state, ST_IDLE);

      // 2. normal generate
      issue(15'o43210, 5, 0, 0, 0);
      wait_done();
      chk("norm_valid", valid, 1);
      chk("norm_kicks", kicks, 1);
      rd_idx = 3'd3; #1 chk("rd_idx3", rd_data, 3);
      rd_idx = 3'd4; #1 chk("rd_idx4", rd_data, 4);
      rd_idx = 3'd0; #1 chk("rd_idx0", rd_data, 0);
      rd_idx = 3'd6; #1 chk("rd_idx6", rd_data, 0);
      rd_idx = 3'd5; #1 chk("rd_idx5", rd_data, 0);

      // 3. timeout, then recovery
      issue(15'o77777, 5, 1, 0, 0);
      wait_done();
      chk("to_error", error, 1);
      chk("to_digits_hold", digits, 15'o43210);
      issue(15'o56701, 5, 0, 0, 0);
      chk("rekick_error_clr", error, 0);
      chk("rekick_busy", busy, 1);
      wait_done();
      chk("rekick_valid", valid, 1);
      chk("rekick_kicks", kicks, 3);

      // 4. level req held high, and a req pulse during WAIT
      issue(15'o24613, 5, 0, 0, 1);
      wait_done();
      repeat (5) @(negedge clk);
      req = 1'b0;
      chk("hold_kicks", kicks, 4);
      issue(15'o13572, 5, 0, 0, 0);
      repeat (2) @(negedge clk);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      wait_done();
      repeat (20) @(negedge clk);
      chk("pulse_kicks", kicks, 5);

      // 5. stale done, then done coinciding with the last WAIT cycle
      issue(15'o31647, 5, 0, 1, 0);
      wait_done();
      issue(15'o65432, TIMEOUT_CYC_D, 0, 0, 0);
      wait_done();
      chk("coinc_error", error, 0);

      // 6. reset during SETTLE, then a fresh run
      issue(15'o55555, 5, 0, 0, 0);
      sb.delete();
      k0 = 0;
      while (cyc != n_req + 7 && k0 < 50) begin
         @(negedge clk);
         k0++;
      end
      chk("mid_in_settle", dut.state, ST_SETTLE);
      #2 rst = 1'b1;
      #1;
      chk("mid_busy", busy, 0);
      chk("mid_valid", valid, 0);
      chk("mid_s0", gen_s0, 0);
      chk("mid_digits", digits, 0);
      chk("mid_state", dut.state, ST_IDLE);
      @(negedge clk);
      rst = 1'b0;
      issue(15'o01234, 5, 0, 0, 0);
      wait_done();
      rd_idx = 3'd2; #1 chk("fresh_rd2", rd_data, 2);
      rd_idx = 3'd0; #1 chk("fresh_rd0", rd_data, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
